// File: rtl/phy_lane_ctrl.sv
// phy_lane_ctrl: link-activation controller for a two-lane PHY transmitter.
// Qualifies far-end lane sync, enables striping once the link is stable and
// the datapath is between bursts, and counts words recirculated while down.
module phy_lane_ctrl #(
    parameter int SYNC_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk_f,
    input  logic             reset_L,
    input  logic             lane0_sync,
    input  logic             lane1_sync,
    input  logic             valid_in,
    input  logic             cnt_clr,
    output logic             active_lane0,
    output logic             active_lane1,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] recirc_count
);

    localparam int SW = $clog2(SYNC_CNT) + 1;
    localparam int LW = $clog2(LOSS_CNT) + 1;
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_CNT - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        TRAIN  = 2'b01,
        ARM    = 2'b10,
        ACTIVE = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    sync_cnt_q, sync_cnt_d;
    logic [LW-1:0]    loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0] recirc_q;
    logic             both_sync;
    logic             active;

    assign both_sync = lane0_sync & lane1_sync;

    // State register together with the sync/loss qualification counters.
    always_ff @(posedge clk_f) begin
        if (!reset_L) begin
            state_q    <= IDLE;
            sync_cnt_q <= '0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    // Next-state and counter update; counters are cleared on every exit to IDLE.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        loss_cnt_d = loss_cnt_q;
        unique case (state_q)
            IDLE: begin
                sync_cnt_d = '0;
                loss_cnt_d = '0;
                if (both_sync) begin
                    state_d    = TRAIN;
                    sync_cnt_d = SW'(1);
                end
            end
            TRAIN: begin
                if (!both_sync) begin
                    state_d    = IDLE;
                    sync_cnt_d = '0;
                end else if (sync_cnt_q == SYNC_LAST) begin
                    state_d = ARM;
                end else begin
                    sync_cnt_d = sync_cnt_q + SW'(1);
                end
            end
            ARM: begin
                // Wait for an idle word slot so a burst is never split.
                if (!both_sync) begin
                    state_d    = IDLE;
                    sync_cnt_d = '0;
                end else if (!valid_in) begin
                    state_d    = ACTIVE;
                    sync_cnt_d = '0;
                    loss_cnt_d = '0;
                end
            end
            ACTIVE: begin
                if (both_sync) begin
                    loss_cnt_d = '0;
                end else if (loss_cnt_q == LOSS_LAST) begin
                    state_d    = IDLE;
                    loss_cnt_d = '0;
                end else begin
                    loss_cnt_d = loss_cnt_q + LW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                sync_cnt_d = '0;
                loss_cnt_d = '0;
            end
        endcase
    end

    // Moore output decode straight from the state register.
    always_comb begin
        active = (state_q == ACTIVE);
    end

    // Saturating recirculation counter; clear wins over increment.
    always_ff @(posedge clk_f) begin
        if (!reset_L) begin
            recirc_q <= '0;
        end else if (cnt_clr) begin
            recirc_q <= '0;
        end else if (valid_in && (state_q != ACTIVE) && (recirc_q != '1)) begin
            recirc_q <= recirc_q + CNT_W'(1);
        end
    end

    assign active_lane0 = active;
    assign active_lane1 = active;
    assign state        = state_q;
    assign recirc_count = recirc_q;

endmodule

// File: tb/tb_phy_lane_ctrl.sv
// Scoreboard bench for phy_lane_ctrl: a run-length reference model predicts
// the post-edge outputs, a monitor compares them after every rising edge.
module tb_phy_lane_ctrl;

    localparam int SYNC_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int CNT_W    = 4;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic             clk_f;
    logic             reset_L;
    logic             lane0_sync;
    logic             lane1_sync;
    logic             valid_in;
    logic             cnt_clr;
    logic             active_lane0;
    logic             active_lane1;
    logic [1:0]       state;
    logic [CNT_W-1:0] recirc_count;

    phy_lane_ctrl #(
        .SYNC_CNT(SYNC_CNT),
        .LOSS_CNT(LOSS_CNT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_f       (clk_f),
        .reset_L     (reset_L),
        .lane0_sync  (lane0_sync),
        .lane1_sync  (lane1_sync),
        .valid_in    (valid_in),
        .cnt_clr     (cnt_clr),
        .active_lane0(active_lane0),
        .active_lane1(active_lane1),
        .state       (state),
        .recirc_count(recirc_count)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    typedef struct {
        logic [1:0] st;
        logic       act;
        int         cnt;
        int         idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_idx = 0;

    // Reference model: link described by run lengths of sync / loss samples.
    bit m_active = 1'b0;
    int m_run    = 0;   // consecutive both-sync samples while link is down
    int m_loss   = 0;   // consecutive unsynced samples while link is up
    int m_cnt    = 0;

    function automatic void model_edge(input bit rst, input bit l0, input bit l1,
                                       input bit v, input bit clr);
        bit both;
        bit was_active;
        both       = l0 & l1;
        was_active = m_active;
        if (!rst) begin
            m_active = 1'b0;
            m_run    = 0;
            m_loss   = 0;
            m_cnt    = 0;
            return;
        end
        if (clr) m_cnt = 0;
        else if (v && !was_active && m_cnt < CMAX) m_cnt = m_cnt + 1;
        if (m_active) begin
            if (both) m_loss = 0;
            else begin
                m_loss = m_loss + 1;
                if (m_loss == LOSS_CNT) begin
                    m_active = 1'b0;
                    m_loss   = 0;
                    m_run    = 0;
                end
            end
        end else begin
            if (!both) m_run = 0;
            else if (m_run >= SYNC_CNT && !v) begin
                m_active = 1'b1;
                m_run    = 0;
                m_loss   = 0;
            end else if (m_run < SYNC_CNT) m_run = m_run + 1;
        end
    endfunction

    function automatic logic [1:0] model_state();
        if (m_active) return 2'b11;
        if (m_run == 0) return 2'b00;
        if (m_run < SYNC_CNT) return 2'b01;
        return 2'b10;
    endfunction

    task automatic step(input logic rst, input logic l0, input logic l1,
                        input logic v, input logic clr);
        exp_t e;
        @(negedge clk_f);
        reset_L    = rst;
        lane0_sync = l0;
        lane1_sync = l1;
        valid_in   = v;
        cnt_clr    = clr;
        model_edge(rst, l0, l1, v, clr);
        e.st  = model_state();
        e.act = m_active;
        e.cnt = m_cnt;
        e.idx = step_idx;
        step_idx++;
        sb.push_back(e);
    endtask

    // Monitor: after each rising edge, pop the expected response and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_f);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if (state !== e.st) begin
                    n_errors++;
                    $display("FAIL state step %0d: got %0d, expected %0d", e.idx, state, e.st);
                end
                n_checks++;
                if (active_lane0 !== e.act || active_lane1 !== e.act) begin
                    n_errors++;
                    $display("FAIL active step %0d: got %b%b, expected %b%b",
                             e.idx, active_lane1, active_lane0, e.act, e.act);
                end
                n_checks++;
                if ({1'b0, recirc_count} !== (CNT_W+1)'(e.cnt)) begin
                    n_errors++;
                    $display("FAIL recirc step %0d: got %0d, expected %0d", e.idx, recirc_count, e.cnt);
                end
            end
        end
    end

    initial begin
        int p;
        reset_L    = 1'b0;
        lane0_sync = 1'b0;
        lane1_sync = 1'b0;
        valid_in   = 1'b0;
        cnt_clr    = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        // Nominal bring-up
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Deferred arm with recirculation count
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Glitch in TRAIN at sync count 2, then full restart
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Loss in ACTIVE: short pulse survives, longer pulse drops the link
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Saturation, clear priority, count after clear
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with alternating sync-quality phases
        for (int blk = 0; blk < 10; blk++) begin
            p = (blk % 2 == 0) ? 16 : 3;
            for (int i = 0; i < 200; i++)
                step(1'($urandom_range(0, 199) != 0),
                     1'($urandom_range(0, p - 1) != 0),
                     1'($urandom_range(0, p - 1) != 0),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 15) == 0));
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk_f);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/phy_lane_ctrl.md
# phy_lane_ctrl

Link-activation controller for the two-lane PHY transmitter. It watches per-lane synchronization status returned from the far end and decides when the transmit datapath may stripe traffic onto the lanes. It drives `active_lane0`/`active_lane1` into the transmitter, which recirculates words until both are high. It also counts words recirculated while the link is down.

## Interface
Parameters:
- `SYNC_CNT`, 4: consecutive cycles with both lanes synced required before arming; legal range ≥2.
- `LOSS_CNT`, 3: consecutive cycles with any lane unsynced required to drop the link; legal range ≥1.
- `CNT_W`, 16: width of the recirculation counter.

Ports:
- `clk_f`, input, 1: single clock, one word per cycle; all logic on rising edge.
- `reset_L`, input, 1: synchronous, active-low reset.
- `lane0_sync`, input, 1: far end reports lane 0 synchronized.
- `lane1_sync`, input, 1: far end reports lane 1 synchronized.
- `valid_in`, input, 1: word presented to transmitter this cycle.
- `cnt_clr`, input, 1: synchronous clear of `recirc_count`.
- `active_lane0`, output, 1: lane 0 enabled for striping.
- `active_lane1`, output, 1: lane 1 enabled for striping.
- `state`, output, 2: current FSM state.
- `recirc_count`, output, CNT_W: saturating count of words recirculated.

## Operation
- Define `both_sync = lane0_sync & lane1_sync`. All decisions use values sampled at the rising edge of `clk_f`.
- FSM encoding: IDLE=2'b00, TRAIN=2'b01, ARM=2'b10, ACTIVE=2'b11.
- IDLE: `sync_cnt`=0 and `loss_cnt`=0. If `both_sync`, go to TRAIN and load `sync_cnt`=1.
- TRAIN:
  - If `!both_sync`, go to IDLE and clear `sync_cnt`.
  - Else if `sync_cnt == SYNC_CNT-1`, go to ARM.
  - Else increment `sync_cnt`.
- ARM:
  - If `!both_sync`, go to IDLE.
  - Else if `valid_in==0`, go to ACTIVE. Activation is deferred until an idle cycle so a burst is never split between recirculation and striping.
  - Else stay in ARM.
- ACTIVE:
  - If `both_sync`, `loss_cnt`=0.
  - Else if `loss_cnt == LOSS_CNT-1`, go to IDLE and clear `loss_cnt`.
  - Else increment `loss_cnt`.
- `active_lane0 = active_lane1 = (state == ACTIVE)`. These are Moore outputs decoded directly from the state register, with no combinational path from inputs.
- `recirc_count`:
  - On each edge, if `cnt_clr`, load 0.
  - Else if `valid_in && state != ACTIVE`, increment, saturating at all-ones.
  - `cnt_clr` wins over a simultaneous increment.
  - The counter is unaffected by state transitions; only reset or `cnt_clr` clears it.
- Internal counter widths: `sync_cnt` is `$clog2(SYNC_CNT)+1` bits and `loss_cnt` is `$clog2(LOSS_CNT)+1` bits. Neither counter may wrap.

## Timing
- Reset (`reset_L`=0 at an edge) sets:
  - `state`=IDLE;
  - `active_lane0`=0, `active_lane1`=0;
  - `recirc_count`=0;
  - internal counters to 0.
- Reset mid-operation, from any state, takes effect at that edge. Reset has priority over all other inputs.
- Minimum activation latency, with `both_sync` first sampled high at edge e0 and `valid_in`=0:
  - TRAIN after e0;
  - ARM after e(SYNC_CNT-1);
  - ACTIVE, with outputs high, after e(SYNC_CNT).
  - For SYNC_CNT=4, outputs rise after the 5th edge.
- Each cycle `valid_in`=1 in ARM adds one cycle of latency.
- Drop latency: outputs fall after the LOSS_CNT-th consecutive edge sampling `!both_sync` in ACTIVE. A single `both_sync` sample restarts the count.
- A sync glitch of one cycle in TRAIN or ARM returns to IDLE, and training restarts from `sync_cnt`=1 on the next qualifying sample.
- `recirc_count` reflects an increment one cycle after the qualifying sample. On the edge where state becomes ACTIVE, that cycle's `valid_in` is evaluated against the pre-edge state.

## Test plan
- Reset: hold `reset_L`=0 for 2 edges with random inputs → `state`=0, both actives 0, `recirc_count`=0.
- Nominal bring-up: both syncs 1, `valid_in`=0 from edge 0 → `state` sequence 00, 01, 01, 01, 10, 11; actives go high after the 5th edge.
- Deferred arm and recirc count: syncs 1, `valid_in`=1 for 8 cycles then 0 → FSM holds in ARM until `valid_in` falls, then goes ACTIVE; `recirc_count`=8.
- Glitch in TRAIN: drop `lane1_sync` for 1 cycle at `sync_cnt`=2 → IDLE, then a full restart; actives rise 5 edges after sync returns.
- Loss in ACTIVE: drop `lane0_sync` for 2 cycles, restore, then drop for 3 cycles → link stays ACTIVE after the first pulse; actives fall after the 3rd low edge of the second pulse.
- Saturation and clear:
  - With CNT_W=4, send 20 valid words while IDLE → `recirc_count`=15.
  - Assert `cnt_clr` together with `valid_in` → `recirc_count`=0.
  - Then send one more valid word → `recirc_count`=1.
